// File: rtl/cmd_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cmd_arbiter_pkg : command codes, default widths and FSM states for          |
// |                   the DDR command-FIFO push arbiter.                        |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
package cmd_arbiter_pkg;

  localparam logic [1:0] CMD_READ  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 27;
  localparam int DEF_BURST_W = 6;
  localparam int DEF_DATA_W  = 128;
  localparam int DEF_MASK_W  = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cmd_arbiter_if : requester-side and FIFO-push-side bundle of cmd_arbiter.   |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
interface cmd_arbiter_if #(
  parameter int NUM_REQ = cmd_arbiter_pkg::DEF_NUM_REQ,
  parameter int ADDR_W  = cmd_arbiter_pkg::DEF_ADDR_W,
  parameter int BURST_W = cmd_arbiter_pkg::DEF_BURST_W,
  parameter int DATA_W  = cmd_arbiter_pkg::DEF_DATA_W,
  parameter int MASK_W  = cmd_arbiter_pkg::DEF_MASK_W
);
  import cmd_arbiter_pkg::*;
  localparam int GID_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [2*NUM_REQ-1:0]       req_cmd_type;
  logic [ADDR_W*NUM_REQ-1:0]  req_addr;
  logic [BURST_W*NUM_REQ-1:0] req_burst_cnt;
  logic [DATA_W*NUM_REQ-1:0]  req_wt_data;
  logic [MASK_W*NUM_REQ-1:0]  req_wt_mask;

  logic                       io_push_valid;
  logic                       io_push_ready;
  logic [1:0]                 io_push_cmd_type;
  logic [ADDR_W-1:0]          io_push_addr;
  logic [BURST_W-1:0]         io_push_burst_cnt;
  logic [DATA_W-1:0]          io_push_wt_data;
  logic [MASK_W-1:0]          io_push_wt_mask;
  logic [GID_W-1:0]           grant_id;

  // slave is the arbiter's view; master is the requesters + FIFO side
  modport slave (
    input  req_valid, req_cmd_type, req_addr, req_burst_cnt, req_wt_data, req_wt_mask,
    input  io_push_ready,
    output req_ready,
    output io_push_valid, io_push_cmd_type, io_push_addr, io_push_burst_cnt,
    output io_push_wt_data, io_push_wt_mask, grant_id
  );

  modport master (
    output req_valid, req_cmd_type, req_addr, req_burst_cnt, req_wt_data, req_wt_mask,
    output io_push_ready,
    input  req_ready,
    input  io_push_valid, io_push_cmd_type, io_push_addr, io_push_burst_cnt,
    input  io_push_wt_data, io_push_wt_mask, grant_id
  );

endinterface
`default_nettype wire

// File: rtl/cmd_arbiter_rr.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rr_arbiter : combinational rotating-priority picker; the first request      |
// |              after i_ptr (modulo NUM_REQ) wins.                             |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  wire logic [NUM_REQ-1:0] i_req,
  input  wire logic [IDX_W-1:0]   i_ptr,
  output logic      [NUM_REQ-1:0] o_grant,
  output logic      [IDX_W-1:0]   o_idx
);

  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cmd_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cmd_arbiter : round-robin sharing of the DDR command-FIFO push port; write  |
// |               bursts lock the grant until every beat has been accepted.     |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module cmd_arbiter
  import cmd_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BURST_W = DEF_BURST_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MASK_W  = DEF_MASK_W
) (
  input wire logic    clk,
  input wire logic    rstn,
  cmd_arbiter_if.slave bus
);

  localparam int GID_W = idx_w(NUM_REQ);

  state_t               r_state, w_state_nxt;
  logic [GID_W-1:0]     r_owner, r_rr_ptr, r_grant_id;
  logic [GID_W-1:0]     w_win_idx, w_sel;
  logic [NUM_REQ-1:0]   w_win_oh, w_ready;
  logic [BURST_W-1:0]   r_beats_left;
  logic                 w_slot_free, w_hs, r_push_valid;

  logic [1:0]           w_cmd, r_cmd;
  logic [ADDR_W-1:0]    w_addr, r_addr;
  logic [BURST_W-1:0]   w_burst, r_burst;
  logic [DATA_W-1:0]    w_data, r_data;
  logic [MASK_W-1:0]    w_mask, r_mask;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GID_W)
  ) u_rr (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_win_oh),
    .o_idx   (w_win_idx)
  );

  assign w_slot_free = !r_push_valid || bus.io_push_ready;
  assign w_sel       = (r_state == ST_BURST) ? r_owner : w_win_idx;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    case (r_state)
      ST_IDLE:  w_ready = w_win_oh & {NUM_REQ{w_slot_free}};
      ST_BURST: w_ready[r_owner] = w_slot_free;
      default:  w_ready = '0;
    endcase
    // an accept during reset would be silently lost, so ready is gated by rstn
    w_ready = w_ready & {NUM_REQ{rstn}};
    w_hs    = |(bus.req_valid & w_ready);
    if (w_hs) begin
      if (r_state == ST_IDLE) begin
        if (w_cmd == CMD_WRITE && w_burst != '0) w_state_nxt = ST_BURST;
      end else if (r_beats_left == BURST_W'(1)) begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_comb begin
    w_cmd   = '0;
    w_addr  = '0;
    w_burst = '0;
    w_data  = '0;
    w_mask  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == GID_W'(i)) begin
        w_cmd   = bus.req_cmd_type[2*i +: 2];
        w_addr  = bus.req_addr[ADDR_W*i +: ADDR_W];
        w_burst = bus.req_burst_cnt[BURST_W*i +: BURST_W];
        w_data  = bus.req_wt_data[DATA_W*i +: DATA_W];
        w_mask  = bus.req_wt_mask[MASK_W*i +: MASK_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // rr_ptr only advances when a command completes, so a burst owner cannot re-win early
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr     <= GID_W'(NUM_REQ - 1);
      r_owner      <= '0;
      r_beats_left <= '0;
    end else if (w_hs) begin
      if (r_state == ST_IDLE) begin
        if (w_state_nxt == ST_BURST) begin
          r_owner      <= w_win_idx;
          r_beats_left <= w_burst;
        end else begin
          r_rr_ptr <= w_win_idx;
        end
      end else begin
        r_beats_left <= r_beats_left - BURST_W'(1);
        if (r_beats_left == BURST_W'(1)) r_rr_ptr <= r_owner;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_push_valid <= 1'b0;
      r_grant_id   <= '0;
      r_cmd        <= '0;
      r_addr       <= '0;
      r_burst      <= '0;
      r_data       <= '0;
      r_mask       <= '0;
    end else if (w_hs) begin
      r_push_valid <= 1'b1;
      r_grant_id   <= w_sel;
      r_cmd        <= w_cmd;
      r_addr       <= w_addr;
      r_burst      <= w_burst;
      r_data       <= w_data;
      r_mask       <= w_mask;
    end else if (bus.io_push_ready) begin
      r_push_valid <= 1'b0;
    end
  end

  assign bus.req_ready         = w_ready;
  assign bus.io_push_valid     = r_push_valid;
  assign bus.io_push_cmd_type  = r_cmd;
  assign bus.io_push_addr      = r_addr;
  assign bus.io_push_burst_cnt = r_burst;
  assign bus.io_push_wt_data   = r_data;
  assign bus.io_push_wt_mask   = r_mask;
  assign bus.grant_id          = r_grant_id;

endmodule
`default_nettype wire
